// File: rtl/wind_pkg.sv
// wind_pkg: shared mode encodings and default widths for the wind averaging datapath
package wind_pkg;
    typedef enum logic [1:0] {
        MODE_BLOCK  = 2'd0,
        MODE_EMA    = 2'd1,
        MODE_BYPASS = 2'd2
    } mode_t;
    localparam int FRAC_BITS  = 10;
    localparam int DEF_DW     = 16;
    localparam int DEF_MAXLOG = 8;
endpackage

// File: rtl/wind_avg_lane.sv
// wind_avg_lane: one channel of the averager; block sum or IIR state, rounding shifter, output register
module wind_avg_lane #(
    parameter int DW     = 16,
    parameter int MAXLOG = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic                 clr,
    input  logic                 first,
    input  logic                 blk,
    input  logic                 ema,
    input  logic                 done,
    input  logic [3:0]           l_blk,
    input  logic [3:0]           l_ema,
    input  logic signed [DW-1:0] x,
    output logic signed [DW-1:0] y
);
    localparam int AW = DW + MAXLOG;
    localparam logic signed [AW:0] HALF = (AW+1)'(1) << (MAXLOG - 1);
    logic signed [AW-1:0] acc, acc_nxt;
    logic signed [AW:0] ae, xe, xs, sum, rb, bavg, yn, eavg;
    logic signed [DW-1:0] res;
    // One extra bit on every intermediate keeps IIR differences and rounding adds from wrapping
    always_comb begin
        ae = clr ? '0 : {acc[AW-1], acc};
        xe = {{(MAXLOG+1){x[DW-1]}}, x};
        xs = xe <<< MAXLOG;
        sum = ae + xe;
        rb = (l_blk == '0) ? '0 : (AW+1)'(1) << (l_blk - 4'd1);
        bavg = (sum + rb) >>> l_blk;
        yn = first ? xs : ae + ((xs - ae) >>> l_ema);
        eavg = (yn + HALF) >>> MAXLOG;
        res = blk ? bavg[DW-1:0] : ema ? eavg[DW-1:0] : x;
        acc_nxt = !in_valid ? ae[AW-1:0] : blk ? (done ? '0 : sum[AW-1:0]) : ema ? yn[AW-1:0] : '0;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            acc <= '0;
            y   <= '0;
        end else begin
            acc <= acc_nxt;
            if (in_valid && (!blk || done)) y <= res;
        end
    end
endmodule

// File: rtl/wind_vec_avg.sv
// wind_vec_avg: NCH-channel block / exponential / bypass averager with shared window control
module wind_vec_avg
    import wind_pkg::*;
#(
    parameter int NCH    = 2,
    parameter int DW     = DEF_DW,
    parameter int MAXLOG = DEF_MAXLOG
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [NCH*DW-1:0]   in_data,
    input  logic [3:0]          meanlen,
    input  logic [1:0]          mode,
    output logic                out_valid,
    output logic [NCH*DW-1:0]   out_data,
    output logic [MAXLOG:0]     win_cnt
);
    localparam logic [3:0] ML = 4'(MAXLOG);
    logic [1:0] mode_q;
    logic first_q, clr, first, blk, ema, done;
    logic [3:0] l_q, l_new, l_blk;
    logic [MAXLOG:0] cnt_base, cnt_nxt, cnt_d;
    // A mode change restarts the window in the same cycle, so a coincident sample opens the new mode
    always_comb begin
        clr = mode != mode_q;
        first = first_q | clr;
        blk = mode == MODE_BLOCK;
        ema = mode == MODE_EMA;
        l_new = (meanlen > ML) ? ML : meanlen;
        cnt_base = clr ? '0 : win_cnt;
        l_blk = (cnt_base == '0) ? l_new : l_q;
        cnt_nxt = cnt_base + 1'b1;
        done = blk && in_valid && (cnt_nxt == ((MAXLOG+1)'(1) << l_blk));
        cnt_d = !blk ? '0 : !in_valid ? cnt_base : done ? '0 : cnt_nxt;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            mode_q    <= '0;
            first_q   <= 1'b1;
            l_q       <= '0;
            win_cnt   <= '0;
            out_valid <= 1'b0;
        end else begin
            mode_q    <= mode;
            first_q   <= in_valid ? 1'b0 : first;
            l_q       <= l_blk;
            win_cnt   <= cnt_d;
            out_valid <= in_valid && (!blk || done);
        end
    end
    for (genvar k = 0; k < NCH; k++) begin : g_lane
        wind_avg_lane #(.DW(DW), .MAXLOG(MAXLOG)) u_lane (
            .clock    (clock),
            .reset    (reset),
            .in_valid (in_valid),
            .clr      (clr),
            .first    (first),
            .blk      (blk),
            .ema      (ema),
            .done     (done),
            .l_blk    (l_blk),
            .l_ema    (l_new),
            .x        (in_data[k*DW +: DW]),
            .y        (out_data[k*DW +: DW])
        );
    end
endmodule

// File: tb/tb_wind_vec_avg.sv
// tb_wind_vec_avg: directed vectors into wind_vec_avg with a queue scoreboard and output monitor
module tb_wind_vec_avg;
    logic clock = 1'b0, reset, in_valid;
    logic [31:0] in_data, out_data;
    logic [3:0] meanlen;
    logic [1:0] mode;
    logic out_valid;
    logic [8:0] win_cnt;
    int cyc = 0, checks = 0, errors = 0;
    typedef struct {
        logic signed [15:0] a;
        logic signed [15:0] b;
        int due;
    } exp_t;
    exp_t q[$];

    wind_vec_avg dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .meanlen(meanlen), .mode(mode), .out_valid(out_valid), .out_data(out_data),
        .win_cnt(win_cnt)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        #1;
        if (out_valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got out_valid with %0d/%0d, required none at cycle %0d",
                         $signed(out_data[15:0]), $signed(out_data[31:16]), cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (out_data[15:0] !== e.a || out_data[31:16] !== e.b || cyc != e.due) begin
                    errors++;
                    $display("FAIL out_data: got %0d/%0d at cycle %0d, required %0d/%0d at cycle %0d",
                             $signed(out_data[15:0]), $signed(out_data[31:16]), cyc, e.a, e.b, e.due);
                end
            end
        end
    end

    task automatic send(input logic signed [15:0] a, input logic signed [15:0] b,
                        input bit e, input logic signed [15:0] ea, input logic signed [15:0] eb);
        @(negedge clock);
        in_valid = 1'b1;
        in_data = {b, a};
        if (e) q.push_back('{ea, eb, cyc + 1});
    endtask

    task automatic idle();
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; meanlen = 4'd2; mode = 2'd0;
        repeat (2) @(negedge clock);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_data", int'(out_data), 0);
        chk("reset_win_cnt", int'(win_cnt), 0);
        reset = 1'b0;

        send(1024, -1024, 0, 0, 0);
        send(2048, -1024, 0, 0, 0);
        idle();
        chk("block_win_cnt_mid", int'(win_cnt), 2);
        send(3072, -1024, 0, 0, 0);
        send(4096, -1024, 1, 2560, -1024);
        idle();
        chk("block_win_cnt_end", int'(win_cnt), 0);

        meanlen = 4'd1;
        send(-3, 0, 0, 0, 0);
        send(-2, 0, 1, -2, 0);
        send(3, 0, 0, 0, 0);
        send(2, 0, 1, 3, 0);
        idle();

        @(negedge clock);
        in_valid = 1'b1; in_data = {16'sd0, 16'sd1000}; mode = 2'd1;
        q.push_back('{16'sd1000, 16'sd0, cyc + 1});
        send(2000, 0, 1, 1500, 0);
        send(2000, 0, 1, 1750, 0);
        send(2000, 0, 1, 1875, 0);
        idle();
        chk("ema_win_cnt", int'(win_cnt), 0);

        mode = 2'd0; meanlen = 4'd2;
        send(8, -8, 0, 0, 0);
        send(12, -8, 0, 0, 0);
        meanlen = 4'd0;
        send(16, -8, 0, 0, 0);
        send(20, -8, 1, 14, -8);
        send(5, 9, 1, 5, 9);
        send(-7, -1, 1, -7, -1);
        idle();

        meanlen = 4'd2;
        send(1, 1, 0, 0, 0);
        send(2, 2, 0, 0, 0);
        send(3, 3, 0, 0, 0);
        @(negedge clock);
        reset = 1'b1; in_valid = 1'b1; in_data = {16'sd4, 16'sd4};
        @(negedge clock);
        reset = 1'b0; in_valid = 1'b0;
        chk("reset_mid_win_cnt", int'(win_cnt), 0);
        for (int i = 0; i < 4; i++) send(100, 100, i == 3, 100, 100);
        send(50, 50, 0, 0, 0);
        send(50, 50, 0, 0, 0);
        idle();
        chk("pre_switch_win_cnt", int'(win_cnt), 2);
        mode = 2'd1;
        idle();
        chk("post_switch_win_cnt", int'(win_cnt), 0);
        send(500, -500, 1, 500, -500);
        send(700, -700, 1, 550, -550);
        idle();

        mode = 2'd2;
        send(123, -456, 1, 123, -456);
        idle();

        mode = 2'd0; meanlen = 4'd12;
        idle();
        for (int i = 0; i < 256; i++) begin
            send(-32768, 32767, i == 255, -32768, 32767);
            if (i == 128) chk("long_win_cnt", int'(win_cnt), 128);
        end
        idle();
        chk("long_win_cnt_end", int'(win_cnt), 0);

        repeat (3) idle();
        chk("scoreboard_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
